core_data_req_buffer: RTL and testbench

- Sits directly downstream of each core's data port in the cluster: consumes the `core_data_req_t` request bundle and produces the `core_data_rsp_t` response bundle.
- Upstream side talks to the core; downstream side talks to the cluster data interconnect (TCDM / periph demux).
- Registers and queues core requests so that the core grant no longer depends combinationally on the interconnect grant.
- Limits in-flight transactions to a programmable maximum and registers the response path, which removes the core↔interconnect timing path.

---
 rtl/core_data_req_buffer_pkg.sv | 28 ++
 rtl/core_data_req_fifo.sv | 49 ++++
 rtl/core_data_req_buffer.sv | 114 +++++++++++
 tb/tb_core_data_req_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_data_req_buffer_pkg.sv
// Shared cluster types for the core data port.
// Request/response bundles, queued-entry type, outstanding default.
package core_data_req_buffer_pkg;

  localparam int unsigned CORE_DATA_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;

  typedef struct packed {
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } req_entry_t;

endpackage

// File: rtl/core_data_req_fifo.sv
// Request FIFO holding accepted core requests.
// Ports: clk_i, rst_i, i_push/i_data, i_pop, o_head, o_full, o_empty.
module core_data_req_fifo
  import core_data_req_buffer_pkg::*;
#(
  parameter int unsigned ReqDepth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_push,
  input  req_entry_t i_data,
  input  logic       i_pop,
  output req_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;

  req_entry_t r_mem [ReqDepth];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_wr;
  logic        w_rd;

  // Same index, different lap bit means the FIFO is full.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_wr   = i_push && !o_full;
  assign w_rd   = i_pop && !o_empty;
  assign o_head = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/core_data_req_buffer.sv
// Decouples a core data port from the cluster interconnect.
// Ports: core_req_i/core_rsp_o (core), mem_req_o/mem_rsp_i (interconnect),
// outstanding_o, busy_o, err_unexp_rsp_o, err_clr_i.
module core_data_req_buffer
  import core_data_req_buffer_pkg::*;
#(
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned MaxOutstanding = CORE_DATA_MAX_OUTSTANDING,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  core_data_req_t      core_req_i,
  output core_data_rsp_t      core_rsp_o,
  output core_data_req_t      mem_req_o,
  input  core_data_rsp_t      mem_rsp_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                busy_o,
  output logic                err_unexp_rsp_o,
  input  logic                err_clr_i
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  req_entry_t          w_entry;
  req_entry_t          w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_issue;
  logic                w_can_issue;
  logic                w_rsp_ok;
  logic                w_unexp;
  logic [CntWidth-1:0] r_cnt;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic                r_err;

  assign w_entry = '{add:  core_req_i.add,
                     we:   core_req_i.we,
                     data: core_req_i.data,
                     be:   core_req_i.be};

  assign w_push = core_req_i.req && !w_full;

  // A response in this cycle frees a slot for an issue in this cycle.
  assign w_can_issue = (r_cnt < MaxCnt) || mem_rsp_i.r_valid;
  assign w_issue     = !w_empty && w_can_issue;
  assign w_pop       = w_issue && mem_rsp_i.gnt;
  assign w_rsp_ok    = mem_rsp_i.r_valid && (r_cnt != '0);
  assign w_unexp     = mem_rsp_i.r_valid && (r_cnt == '0);

  core_data_req_fifo #(
    .ReqDepth(ReqDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_push (w_push),
    .i_data (w_entry),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    mem_req_o = '0;
    if (w_issue) begin
      mem_req_o.req  = 1'b1;
      mem_req_o.add  = w_head.add;
      mem_req_o.we   = w_head.we;
      mem_req_o.data = w_head.data;
      mem_req_o.be   = w_head.be;
    end
  end

  assign core_rsp_o = '{gnt:     !w_full,
                        r_data:  r_rdata,
                        r_valid: r_rvalid};

  assign outstanding_o   = r_cnt;
  assign busy_o          = !w_empty || (r_cnt != '0);
  assign err_unexp_rsp_o = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_pop, w_rsp_ok})
        2'b10: if (r_cnt < MaxCnt) r_cnt <= r_cnt + 1'b1;
        2'b01: r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= mem_rsp_i.r_valid;
      if (mem_rsp_i.r_valid) r_rdata <= mem_rsp_i.r_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_err <= 1'b0;
    else if (w_unexp) r_err <= 1'b1;
    else if (err_clr_i) r_err <= 1'b0;
  end

endmodule

// File: tb/tb_core_data_req_buffer.sv
// Scoreboard bench for core_data_req_buffer.
// Interconnect model + decoupled core response monitor.
module tb_core_data_req_buffer;
  import core_data_req_buffer_pkg::*;

  logic           clk = 1'b0;
  logic           rst_i;
  core_data_req_t core_req_i;
  core_data_rsp_t core_rsp_o;
  core_data_req_t mem_req_o;
  core_data_rsp_t mem_rsp_i;
  logic [2:0]     outstanding_o;
  logic           busy_o;
  logic           err_unexp_rsp_o;
  logic           err_clr_i;

  always #5 clk = ~clk;

  core_data_req_buffer dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .core_req_i     (core_req_i),
    .core_rsp_o     (core_rsp_o),
    .mem_req_o      (mem_req_o),
    .mem_rsp_i      (mem_rsp_i),
    .outstanding_o  (outstanding_o),
    .busy_o         (busy_o),
    .err_unexp_rsp_o(err_unexp_rsp_o),
    .err_clr_i      (err_clr_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit          mem_gnt    = 1'b0;
  bit          rsp_hold   = 1'b1;
  int          rel_cnt    = 0;
  bit          force_rv   = 1'b0;
  logic [31:0] force_data = '0;

  req_entry_t  req_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          exp_out = 0;
  int          max_out = 0;
  int          n_hs    = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rsp_of(input req_entry_t e);
    return e.we ? 32'h0 : {16'hCAFE, e.add[15:0]};
  endfunction

  // Interconnect model and per-cycle reference checks.
  initial begin
    logic        rv;
    logic [31:0] rd;
    bit          hs;
    bit          exp_req;
    req_entry_t  e;
    mem_rsp_i = '0;
    forever begin
      @(negedge clk);
      #1;
      rv = 1'b0;
      rd = '0;
      if (force_rv) begin
        rv = 1'b1;
        rd = force_data;
        force_rv = 1'b0;
      end else if (pend_q.size() > 0 && (!rsp_hold || rel_cnt > 0)) begin
        rv = 1'b1;
        rd = pend_q.pop_front();
        if (rsp_hold) rel_cnt--;
      end
      mem_rsp_i = '{gnt: mem_gnt, r_data: rd, r_valid: rv};
      #1;
      if (rst_i) begin
        req_q.delete();
        exp_out = 0;
      end else begin
        exp_req = (req_q.size() != 0) && (exp_out < 4 || rv);
        chk("cyc_outstanding", 32'(outstanding_o), 32'(exp_out));
        chk("cyc_mem_req", 32'(mem_req_o.req), 32'(exp_req));
        chk("cyc_core_gnt", 32'(core_rsp_o.gnt), 32'(req_q.size() < 2));
        chk("cyc_busy", 32'(busy_o),
            32'(req_q.size() != 0 || exp_out != 0));
        if (!mem_req_o.req)
          chk("cyc_idle_zero", mem_req_o.add | mem_req_o.data |
              {28'b0, mem_req_o.be} | {31'b0, mem_req_o.we}, 32'h0);
        if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);
        if (rv) exp_q.push_back(rd);
        hs = mem_req_o.req && mem_gnt;
        if (hs) begin
          n_hs++;
          if (req_q.size() == 0) begin
            chk("hs_unexpected_issue", 32'h1, 32'h0);
          end else begin
            e = req_q.pop_front();
            chk("hs_add", mem_req_o.add, e.add);
            chk("hs_data", mem_req_o.data, e.data);
            chk("hs_we_be", {27'b0, mem_req_o.we, mem_req_o.be},
                {27'b0, e.we, e.be});
            pend_q.push_back(rsp_of(e));
          end
        end
        if (core_req_i.req && core_rsp_o.gnt)
          req_q.push_back('{add: core_req_i.add, we: core_req_i.we,
                            data: core_req_i.data, be: core_req_i.be});
        if (hs && !(rv && exp_out > 0)) exp_out++;
        else if (!hs && rv && exp_out > 0) exp_out--;
      end
    end
  end

  // Core response monitor.
  initial begin
    logic [31:0] x;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_i && core_rsp_o.r_valid === 1'b1) begin
        got_q.push_back(core_rsp_o.r_data);
        if (exp_q.size() == 0) begin
          chk("mon_extra_rvalid", 32'h1, 32'h0);
        end else begin
          x = exp_q.pop_front();
          chk("mon_rdata", core_rsp_o.r_data, x);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] b,
                      output int waits);
    waits = 0;
    core_req_i = '{req: 1'b1, add: a, we: w, data: d, be: b};
    #3;
    while (core_rsp_o.gnt !== 1'b1 && waits < 50) begin
      @(negedge clk);
      #3;
      waits++;
    end
    if (waits >= 50) chk("send_timeout", 32'h1, 32'h0);
    @(negedge clk);
    core_req_i = '0;
  endtask

  task automatic drain();
    int n;
    rsp_hold = 1'b0;
    mem_gnt  = 1'b1;
    n = 0;
    while (n < 80) begin
      @(negedge clk);
      #3;
      if (req_q.size() == 0 && pend_q.size() == 0 &&
          exp_q.size() == 0 && exp_out == 0) break;
      n++;
    end
    chk("drain_done", 32'(n < 80), 32'h1);
    chk("drain_busy", 32'(busy_o), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int w;
    int waits;
    rst_i      = 1'b1;
    core_req_i = '0;
    err_clr_i  = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #3;
    chk("rst_gnt", 32'(core_rsp_o.gnt), 32'h1);
    chk("rst_rvalid", 32'(core_rsp_o.r_valid), 32'h0);
    chk("rst_rdata", core_rsp_o.r_data, 32'h0);
    chk("rst_mem_req", 32'(mem_req_o != '0), 32'h0);
    chk("rst_out", 32'(outstanding_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err", 32'(err_unexp_rsp_o), 32'h0);
    @(negedge clk);

    // Back-to-back reads, interconnect always grants and answers.
    rsp_hold = 1'b0;
    mem_gnt  = 1'b1;
    max_out  = 0;
    waits    = 0;
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 4'hF, w);
      waits += w;
    end
    drain();
    chk("b2b_gnt_waits", 32'(waits), 32'h0);
    chk("b2b_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk("b2b_data", got_q[i], 32'hCAFE1000 + 32'(4 * i));
    chk("b2b_max_out", 32'(max_out <= 2), 32'h1);

    // Outstanding cap, then release one response.
    rsp_hold = 1'b1;
    rel_cnt  = 0;
    n_hs     = 0;
    got_q.delete();
    for (int i = 0; i < 6; i++)
      send(32'h3000 + 32'(4 * i), 1'b0, 32'h0, 4'hF, w);
    #3;
    chk("cap_out", 32'(outstanding_o), 32'd4);
    chk("cap_hs", 32'(n_hs), 32'd4);
    chk("cap_mem_req", 32'(mem_req_o.req), 32'h0);
    chk("cap_gnt", 32'(core_rsp_o.gnt), 32'h0);
    chk("cap_busy", 32'(busy_o), 32'h1);
    @(negedge clk);
    rel_cnt = 1;
    #3;
    chk("cap_issue_same_cycle", 32'(mem_req_o.req), 32'h1);
    @(negedge clk);
    #3;
    chk("simul_out", 32'(outstanding_o), 32'd4);
    chk("simul_hs", 32'(n_hs), 32'd5);
    @(negedge clk);
    drain();
    chk("cap_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk("cap_data", got_q[i], 32'hCAFE3000 + 32'(4 * i));

    // Interconnect stall with a write at the head.
    mem_gnt = 1'b0;
    send(32'h2000, 1'b1, 32'hDEADBEEF, 4'hF, w);
    send(32'h2004, 1'b1, 32'h01234567, 4'h3, w);
    #3;
    chk("stall_full_gnt", 32'(core_rsp_o.gnt), 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_req", 32'(mem_req_o.req), 32'h1);
      chk("stall_add", mem_req_o.add, 32'h2000);
      chk("stall_data", mem_req_o.data, 32'hDEADBEEF);
      chk("stall_we_be", {27'b0, mem_req_o.we, mem_req_o.be}, 32'h1F);
      @(negedge clk);
      #3;
    end
    @(negedge clk);
    drain();

    // Unexpected response, sticky flag, clear, set-over-clear.
    force_data = 32'h12345678;
    force_rv   = 1'b1;
    @(negedge clk);
    #3;
    chk("unexp_rvalid", 32'(core_rsp_o.r_valid), 32'h1);
    chk("unexp_rdata", core_rsp_o.r_data, 32'h12345678);
    chk("unexp_err", 32'(err_unexp_rsp_o), 32'h1);
    chk("unexp_out", 32'(outstanding_o), 32'h0);
    @(negedge clk);
    #3;
    chk("unexp_pulse", 32'(core_rsp_o.r_valid), 32'h0);
    @(negedge clk);
    #3;
    chk("unexp_sticky", 32'(err_unexp_rsp_o), 32'h1);
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    #3;
    chk("err_cleared", 32'(err_unexp_rsp_o), 32'h0);
    @(negedge clk);
    force_data = 32'h0BADF00D;
    force_rv   = 1'b1;
    err_clr_i  = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    #3;
    chk("err_set_prio", 32'(err_unexp_rsp_o), 32'h1);
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    #3;
    chk("err_cleared2", 32'(err_unexp_rsp_o), 32'h0);
    @(negedge clk);

    // Reset with 3 in flight and 2 queued.
    rsp_hold = 1'b1;
    mem_gnt  = 1'b1;
    for (int i = 0; i < 3; i++)
      send(32'h4000 + 32'(4 * i), 1'b0, 32'h0, 4'hF, w);
    @(negedge clk);
    mem_gnt = 1'b0;
    send(32'h400C, 1'b0, 32'h0, 4'hF, w);
    send(32'h4010, 1'b0, 32'h0, 4'hF, w);
    #3;
    chk("pre_rst_out", 32'(outstanding_o), 32'd3);
    chk("pre_rst_gnt", 32'(core_rsp_o.gnt), 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #3;
    chk("mrst_out", 32'(outstanding_o), 32'h0);
    chk("mrst_busy", 32'(busy_o), 32'h0);
    chk("mrst_mem_req", 32'(mem_req_o.req), 32'h0);
    chk("mrst_gnt", 32'(core_rsp_o.gnt), 32'h1);
    chk("mrst_rvalid", 32'(core_rsp_o.r_valid), 32'h0);
    @(negedge clk);
    rsp_hold = 1'b0;
    mem_gnt  = 1'b1;
    @(negedge clk);
    #3;
    chk("stale_err", 32'(err_unexp_rsp_o), 32'h1);
    drain();
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    #3;
    chk("final_err_clr", 32'(err_unexp_rsp_o), 32'h0);
    chk("final_exp_q", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
